cnt10_load_counter: RTL and testbench



---
 rtl/cnt10_load_counter_if.sv | 20 ++
 rtl/cnt10_load_counter.sv | 57 +++++
 tb/tb_cnt10_load_counter.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/cnt10_load_counter_if.sv
// Control and data bundle for one cnt10_load_counter decade stage.
// Defining CNT10_LOADERR_EN adds the sticky load_err flag to the bundle.
interface cnt10_load_counter_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             load;
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] dout;
  logic             cout;
`ifdef CNT10_LOADERR_EN
  logic             load_err;

  modport master (output en, load, data, input dout, cout, load_err);
  modport slave  (input en, load, data, output dout, cout, load_err);
`else
  modport master (output en, load, data, input dout, cout);
  modport slave  (input en, load, data, output dout, cout);
`endif
endinterface

// File: rtl/cnt10_load_counter.sv
// Modulo-MODULUS up-counter with synchronous reset, parallel load, enable and carry.
// Optional feature macro: CNT10_LOADERR_EN (sticky out-of-range load flag).
module cnt10_load_counter #(
  parameter int MODULUS = 10,
  parameter int WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  cnt10_load_counter_if.slave   bus
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  if (MODULUS < 2 || MODULUS > 256 || $clog2(MODULUS) > WIDTH) begin : g_bad_params
    $error("cnt10_load_counter: MODULUS must be 2..256 and MODULUS-1 must fit in WIDTH");
  end

  logic [WIDTH-1:0] count;
  logic             at_last;
  logic             data_ok;

  assign at_last = (count == LAST);
  assign data_ok = (bus.data <= LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; reset is checked inside the clocked branch,
  // so there is deliberately no asynchronous path.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (!bus.load) begin
      count <= data_ok ? bus.data : '0;
    end else if (bus.en) begin
      count <= at_last ? '0 : count + ONE;
    end
  end

  assign bus.dout = count;
  // Carry is purely combinational so a cascaded stage sees EN changes in-cycle.
  assign bus.cout = at_last & bus.en;

`ifdef CNT10_LOADERR_EN
  logic load_err_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      load_err_q <= 1'b0;
    end else if (!bus.load && !data_ok) begin
      load_err_q <= 1'b1;
    end
  end

  assign bus.load_err = load_err_q;
`endif

endmodule

// File: tb/tb_cnt10_load_counter.sv
// Self-checking bench for cnt10_load_counter: directed scenarios plus random traffic
// compared against an arithmetic model of the counting rules.
module tb_cnt10_load_counter;

  localparam int MODULUS = 10;
  localparam int WIDTH   = 8;

  logic clk = 1'b0;
  logic rst;

  cnt10_load_counter_if #(.WIDTH(WIDTH)) bus ();

  cnt10_load_counter #(.MODULUS(MODULUS), .WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int model_count = 0;
  bit model_err   = 1'b0;

  // Drive one edge's worth of inputs, wait for the edge, advance the model,
  // and return 1 time unit after the edge with inputs unchanged.
  task automatic tick(input logic r, input logic l, input logic e, input logic [WIDTH-1:0] d);
    rst      = r;
    bus.load = l;
    bus.en   = e;
    bus.data = d;
    @(posedge clk);
    if (!r) begin
      model_count = 0;
      model_err   = 1'b0;
    end else if (!l) begin
      if (int'(d) < MODULUS) model_count = int'(d);
      else begin
        model_count = 0;
        model_err   = 1'b1;
      end
    end else if (e) begin
      model_count = (model_count + 1) % MODULUS;
    end
    #1;
  endtask

  function automatic logic exp_cout();
    return (model_count == MODULUS - 1) && bus.en;
  endfunction

  task automatic test_reset();
    tick(1'b0, 1'b0, 1'b1, 8'h03);
    tick(1'b0, 1'b1, 1'b1, 8'h03);
    vectors++;
    if (bus.dout !== 8'd0 || bus.cout !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: dout=%0d cout=%b, expected dout=0 cout=0", bus.dout, bus.cout);
    end
`ifdef CNT10_LOADERR_EN
    vectors++;
    if (bus.load_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_load_err: load_err=%b, expected 0", bus.load_err);
    end
`endif
  endtask

  task automatic test_count();
    for (int i = 0; i < 12; i++) begin
      tick(1'b1, 1'b1, 1'b1, 8'h00);
      vectors++;
      if (bus.dout !== WIDTH'(model_count) || bus.cout !== exp_cout()) begin
        miscompares++;
        $display("FAIL count[%0d]: dout=%0d cout=%b, expected dout=%0d cout=%b",
                 i, bus.dout, bus.cout, model_count, exp_cout());
      end
    end
  endtask

  task automatic test_load_count();
    tick(1'b1, 1'b0, 1'b1, 8'h07);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (bus.dout !== WIDTH'(model_count) || bus.cout !== exp_cout()) begin
        miscompares++;
        $display("FAIL load_count[%0d]: dout=%0d cout=%b, expected dout=%0d cout=%b",
                 i, bus.dout, bus.cout, model_count, exp_cout());
      end
      tick(1'b1, 1'b1, 1'b1, 8'h00);
    end
  endtask

  task automatic test_load_hold();
    tick(1'b1, 1'b0, 1'b0, 8'h05);
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (bus.dout !== 8'd5 || bus.cout !== 1'b0) begin
        miscompares++;
        $display("FAIL load_hold[%0d]: dout=%0d cout=%b, expected dout=5 cout=0",
                 i, bus.dout, bus.cout);
      end
      if (i < 5) tick(1'b1, 1'b1, 1'b0, 8'h00);
    end
    tick(1'b1, 1'b1, 1'b1, 8'h00);
    vectors++;
    if (bus.dout !== 8'd6) begin
      miscompares++;
      $display("FAIL hold_then_count: dout=%0d, expected 6", bus.dout);
    end
  endtask

  task automatic test_out_of_range();
    tick(1'b1, 1'b0, 1'b1, 8'h0C);
    vectors++;
    if (bus.dout !== 8'd0) begin
      miscompares++;
      $display("FAIL oor_load: dout=%0d, expected 0", bus.dout);
    end
    tick(1'b1, 1'b0, 1'b0, 8'h09);
    vectors++;
    if (bus.dout !== 8'd9) begin
      miscompares++;
      $display("FAIL boundary_load: dout=%0d, expected 9", bus.dout);
    end
`ifdef CNT10_LOADERR_EN
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (bus.load_err !== 1'b1) begin
        miscompares++;
        $display("FAIL load_err_sticky[%0d]: load_err=%b, expected 1", i, bus.load_err);
      end
      tick(1'b1, 1'b1, 1'b0, 8'h00);
    end
    tick(1'b0, 1'b1, 1'b0, 8'h00);
    vectors++;
    if (bus.load_err !== 1'b0) begin
      miscompares++;
      $display("FAIL load_err_clear: load_err=%b, expected 0", bus.load_err);
    end
`endif
  endtask

  task automatic test_reset_priority();
    tick(1'b1, 1'b0, 1'b0, 8'h04);
    tick(1'b0, 1'b0, 1'b1, 8'h02);
    vectors++;
    if (bus.dout !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_priority: dout=%0d, expected 0", bus.dout);
    end
  endtask

  task automatic test_carry_gating();
    tick(1'b1, 1'b0, 1'b0, 8'h09);
    bus.load = 1'b1;
    bus.en   = 1'b1;
    #2;
    vectors++;
    if (bus.cout !== 1'b1) begin
      miscompares++;
      $display("FAIL carry_en_high: cout=%b, expected 1", bus.cout);
    end
    bus.en = 1'b0;
    #1;
    vectors++;
    if (bus.cout !== 1'b0) begin
      miscompares++;
      $display("FAIL carry_en_low: cout=%b, expected 0", bus.cout);
    end
    tick(1'b1, 1'b1, 1'b0, 8'h00);
    vectors++;
    if (bus.dout !== 8'd9 || bus.cout !== 1'b0) begin
      miscompares++;
      $display("FAIL carry_hold: dout=%0d cout=%b, expected dout=9 cout=0", bus.dout, bus.cout);
    end
  endtask

  task automatic test_random();
    logic             r, l, e;
    logic [WIDTH-1:0] d;
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(99) >= 3);
      l = ($urandom_range(99) >= 20);
      e = ($urandom_range(99) >= 30);
      d = ($urandom_range(3) == 0) ? WIDTH'($urandom_range(255)) : WIDTH'($urandom_range(12));
      tick(r, l, e, d);
      vectors++;
      if (bus.dout !== WIDTH'(model_count) || bus.cout !== exp_cout()) begin
        miscompares++;
        $display("FAIL random[%0d]: dout=%0d cout=%b, expected dout=%0d cout=%b",
                 i, bus.dout, bus.cout, model_count, exp_cout());
      end
`ifdef CNT10_LOADERR_EN
      vectors++;
      if (bus.load_err !== model_err) begin
        miscompares++;
        $display("FAIL random_load_err[%0d]: load_err=%b, expected %b", i, bus.load_err, model_err);
      end
`endif
    end
  endtask

  initial begin
    rst      = 1'b0;
    bus.en   = 1'b0;
    bus.load = 1'b1;
    bus.data = '0;
    test_reset();
    test_count();
    test_load_count();
    test_load_hold();
    test_out_of_range();
    test_reset_priority();
    test_carry_gating();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
